if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 113 +++++++++++
 tb/tb_if_fetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: a sequential PC feeds a combinational ROM, and each
// fetched {pc, inst} pair goes into a small queue that the decode stage drains.
// Optional macro IF_MISALIGN_EXC_EN adds a sticky misaligned-branch halt.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_inst_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_inst_o,
   output logic [31:0] id_pc_o
`ifdef IF_MISALIGN_EXC_EN
   ,
   output logic        misalign_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   pc_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   branch_pc;
   logic          fetch;
   logic          pop;

`ifdef IF_MISALIGN_EXC_EN
   logic halted_reg;
   logic misalign_reg;

   assign misalign_o = misalign_reg;
   assign fetch      = !rst && !branch_i && (count_reg != FULL) && !halted_reg;
   assign branch_pc  = branch_target_i;

   // A misaligned target halts fetch until an aligned redirect or reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted_reg   <= 1'b0;
         misalign_reg <= 1'b0;
      end else if (branch_i) begin
         halted_reg   <= |branch_target_i[1:0];
         misalign_reg <= |branch_target_i[1:0];
      end
   end
`else
   logic unused_target_bits;

   assign unused_target_bits = ^branch_target_i[1:0];
   assign fetch              = !rst && !branch_i && (count_reg != FULL);
   assign branch_pc          = {branch_target_i[31:2], 2'b00};
`endif

   assign rom_ce_o   = fetch;
   assign rom_addr_o = pc_reg;
   assign id_valid_o = !rst && !branch_i && (count_reg != '0);
   assign pop        = id_valid_o && id_ready_i;
   assign id_inst_o  = inst_mem[rd_ptr_reg];
   assign id_pc_o    = pc_mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      if (fetch && !pop) begin
         count_next = count_reg + CW'(1);
      end else if (!fetch && pop) begin
         count_next = count_reg - CW'(1);
      end
   end

   // Redirect outranks push and pop: the queue is flushed and nothing is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg     <= RESET_PC;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (branch_i) begin
         pc_reg     <= branch_pc;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (fetch) begin
            pc_reg     <= pc_reg + 32'd4;
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (fetch) begin
         pc_mem[wr_ptr_reg]   <= pc_reg;
         inst_mem[wr_ptr_reg] <= rom_inst_i;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: vector table, hand-written corner sequences, then
// random traffic against a queue-based reference model.
module tb_if_fetch;

   logic        clk;
   logic        rst;
   logic        br;
   logic [31:0] tgt;
   logic        rdy;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;

   logic        rom_ce2;
   logic [31:0] rom_addr2;
   logic [31:0] rom_inst2;
   logic        id_valid2;
   logic [31:0] id_inst2;
   logic [31:0] id_pc2;
   logic        br2;
   logic [31:0] tgt2;
   logic        rdy2;

`ifdef IF_MISALIGN_EXC_EN
   logic misalign;
   logic misalign2;
`endif

   int checks = 0;
   int errors = 0;

   // ROM word k holds the value k
   assign rom_inst  = {2'b00, rom_addr[31:2]};
   assign rom_inst2 = {2'b00, rom_addr2[31:2]};

   if_fetch dut (
      .clk(clk), .rst(rst),
      .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
      .branch_i(br), .branch_target_i(tgt),
      .id_valid_o(id_valid), .id_ready_i(rdy),
      .id_inst_o(id_inst), .id_pc_o(id_pc)
`ifdef IF_MISALIGN_EXC_EN
      , .misalign_o(misalign)
`endif
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
      .clk(clk), .rst(rst),
      .rom_ce_o(rom_ce2), .rom_addr_o(rom_addr2), .rom_inst_i(rom_inst2),
      .branch_i(br2), .branch_target_i(tgt2),
      .id_valid_o(id_valid2), .id_ready_i(rdy2),
      .id_inst_o(id_inst2), .id_pc_o(id_pc2)
`ifdef IF_MISALIGN_EXC_EN
      , .misalign_o(misalign2)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        br;
      logic [31:0] tgt;
      logic        rdy;
      logic        ce;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
   } vec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   vec_t tbl [23];
   ent_t q [$];

   function automatic vec_t mk(input logic b, input logic [31:0] t, input logic r,
                               input logic c, input logic [31:0] a, input logic v,
                               input logic [31:0] p, input logic [31:0] i);
      vec_t x;
      x.br = b; x.tgt = t; x.rdy = r; x.ce = c; x.addr = a; x.valid = v; x.pc = p; x.inst = i;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] mpc;
   logic        mhalt;
   logic        mmis;
   logic        exp_ce;
   logic        exp_v;

   initial begin
      // reset drains the queue; fetch is still 4 deep with decode stalled
      tbl[0]  = mk(0, 0, 0, 1, 32'h0,   0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 1, 32'h4,   1, 0, 0);
      tbl[2]  = mk(0, 0, 0, 1, 32'h8,   1, 0, 0);
      tbl[3]  = mk(0, 0, 0, 1, 32'hC,   1, 0, 0);
      for (int k = 4; k <= 9; k++) tbl[k] = mk(0, 0, 0, 0, 32'h10, 1, 0, 0);
      tbl[10] = mk(0, 0, 1, 0, 32'h10,  1, 32'h0,  32'h0);
      tbl[11] = mk(0, 0, 1, 1, 32'h10,  1, 32'h4,  32'h1);
      tbl[12] = mk(0, 0, 1, 1, 32'h14,  1, 32'h8,  32'h2);
      tbl[13] = mk(0, 0, 1, 1, 32'h18,  1, 32'hC,  32'h3);
      tbl[14] = mk(0, 0, 1, 1, 32'h1C,  1, 32'h10, 32'h4);
      tbl[15] = mk(1, 32'h100, 1, 0, 32'h20, 0, 0, 0);
      tbl[16] = mk(0, 0, 1, 1, 32'h100, 0, 0, 0);
      tbl[17] = mk(0, 0, 1, 1, 32'h104, 1, 32'h100, 32'h40);
      tbl[18] = mk(0, 0, 1, 1, 32'h108, 1, 32'h104, 32'h41);
      tbl[19] = mk(1, 32'h200, 1, 0, 32'h10C, 0, 0, 0);
      tbl[20] = mk(1, 32'h300, 1, 0, 32'h200, 0, 0, 0);
      tbl[21] = mk(0, 0, 1, 1, 32'h300, 0, 0, 0);
      tbl[22] = mk(0, 0, 1, 1, 32'h304, 1, 32'h300, 32'hC0);

      rst = 1'b1; br = 1'b0; tgt = '0; rdy = 1'b0;
      br2 = 1'b0; tgt2 = '0; rdy2 = 1'b1;

      @(negedge clk);
      #1;
      chkb("rst_ce", rom_ce, 1'b0);
      chkb("rst_valid", id_valid, 1'b0);
      chk("rst_addr", rom_addr, 32'h0);
      chk("rst_addr2", rom_addr2, 32'hFFFF_FFF8);
`ifdef IF_MISALIGN_EXC_EN
      chkb("rst_misalign", misalign, 1'b0);
`endif
      tick();
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         br = tbl[i].br; tgt = tbl[i].tgt; rdy = tbl[i].rdy;
         #1;
         chkb($sformatf("tbl%0d_ce", i), rom_ce, tbl[i].ce);
         chk($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].addr);
         chkb($sformatf("tbl%0d_valid", i), id_valid, tbl[i].valid);
         if (tbl[i].valid) begin
            chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_inst", i), id_inst, tbl[i].inst);
         end
         if (i >= 1 && i <= 4) begin
            chkb($sformatf("wrap%0d_valid", i), id_valid2, 1'b1);
            chk($sformatf("wrap%0d_pc", i), id_pc2, 32'hFFFF_FFF8 + 32'(4 * (i - 1)));
         end
         $display("vec %0d br=%b tgt=%h rdy=%b ce=%b addr=%h valid=%b pc=%h inst=%h",
                  i, br, tgt, rdy, rom_ce, rom_addr, id_valid, id_pc, id_inst);
         tick();
      end

      // fill the queue, then reset with a concurrent branch that must be ignored
      br = 1'b0; rdy = 1'b0;
      repeat (5) tick();
      #1;
      chkb("full_ce", rom_ce, 1'b0);
      chk("full_pc", id_pc, 32'h304);
      tick();
      rst = 1'b1; br = 1'b1; tgt = 32'h500; rdy = 1'b1;
      #1;
      chkb("midrst_ce", rom_ce, 1'b0);
      chkb("midrst_valid", id_valid, 1'b0);
      tick();
      rst = 1'b0; br = 1'b0;
      #1;
      chkb("postrst_ce", rom_ce, 1'b1);
      chk("postrst_addr", rom_addr, 32'h0);
      chkb("postrst_valid", id_valid, 1'b0);
      tick();
      #1;
      chkb("postrst_valid1", id_valid, 1'b1);
      chk("postrst_pc", id_pc, 32'h0);
      $display("seq midreset pc=%h inst=%h", id_pc, id_inst);
      tick();

      // misaligned branch target
      br = 1'b1; tgt = 32'h102; rdy = 1'b1;
      #1;
      chkb("mis_br_ce", rom_ce, 1'b0);
      chkb("mis_br_valid", id_valid, 1'b0);
      tick();
      br = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
      for (int k = 0; k < 3; k++) begin
         #1;
         chkb("mis_flag", misalign, 1'b1);
         chkb("mis_ce", rom_ce, 1'b0);
         chkb("mis_valid", id_valid, 1'b0);
         tick();
      end
      br = 1'b1; tgt = 32'h200;
      tick();
      br = 1'b0;
      #1;
      chkb("mis_clr", misalign, 1'b0);
      chkb("mis_resume_ce", rom_ce, 1'b1);
      chk("mis_resume_addr", rom_addr, 32'h200);
      tick();
      #1;
      chk("mis_resume_pc", id_pc, 32'h200);
      chk("mis_resume_inst", id_inst, 32'h80);
`else
      #1;
      chkb("mask_ce", rom_ce, 1'b1);
      chk("mask_addr", rom_addr, 32'h100);
      tick();
      #1;
      chkb("mask_valid", id_valid, 1'b1);
      chk("mask_pc", id_pc, 32'h100);
      chk("mask_inst", id_inst, 32'h40);
`endif
      $display("seq misalign pc=%h inst=%h", id_pc, id_inst);
      tick();

      // random traffic against the queue model
      rst = 1'b1; br = 1'b0;
      tick();
      q.delete();
      mpc = 32'h0; mhalt = 1'b0; mmis = 1'b0;
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         br  = ($urandom_range(0, 6) == 0);
         rdy = ($urandom_range(0, 3) != 0);
`ifdef IF_MISALIGN_EXC_EN
         tgt = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
`else
         tgt = $urandom();
`endif
         #1;
         exp_ce = !rst && !br && (q.size() < 4) && !mhalt;
         exp_v  = !rst && !br && (q.size() != 0);
         chkb("rnd_ce", rom_ce, exp_ce);
         chk("rnd_addr", rom_addr, mpc);
         chkb("rnd_valid", id_valid, exp_v);
         if (exp_v) begin
            chk("rnd_pc", id_pc, q[0].pc);
            chk("rnd_inst", id_inst, q[0].inst);
         end
`ifdef IF_MISALIGN_EXC_EN
         chkb("rnd_misalign", misalign, mmis);
`endif
         $display("rnd %0d rst=%b br=%b rdy=%b ce=%b addr=%h valid=%b pc=%h",
                  n, rst, br, rdy, rom_ce, rom_addr, id_valid, id_pc);
         if (rst) begin
            q.delete();
            mpc = 32'h0; mhalt = 1'b0; mmis = 1'b0;
         end else if (br) begin
            q.delete();
`ifdef IF_MISALIGN_EXC_EN
            mpc   = tgt;
            mhalt = (tgt[1:0] != 2'b00);
            mmis  = mhalt;
`else
            mpc = tgt & 32'hFFFF_FFFC;
`endif
         end else begin
            if (exp_v && rdy) void'(q.pop_front());
            if (exp_ce) begin
               q.push_back({mpc, 2'b00, mpc[31:2]});
               mpc = mpc + 32'd4;
            end
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
